// File: rtl/hash_pkg.sv
// Shared definitions for the hash chaining-state register: FSM encoding,
// readout word counts and the SHA-2 initial hash values.
package hash_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_READOUT = 2'd2
  } hash_state_e;

  localparam logic [3:0] CNT_FULL    = 4'd8;
  localparam logic [3:0] CNT_TRUNC32 = 4'd7;
  localparam logic [3:0] CNT_TRUNC64 = 4'd6;

  // H0 sits in the MSBs of every table.
  localparam logic [255:0] IV_SHA256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [255:0] IV_SHA224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [511:0] IV_SHA512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [511:0] IV_SHA384 = {
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

  function automatic logic [63:0] iv_word(input int word_w, input logic mode, input int idx);
    logic [63:0] w;
    if (word_w == 64) begin
      w = mode ? IV_SHA384[(7-idx)*64 +: 64] : IV_SHA512[(7-idx)*64 +: 64];
    end else begin
      w = {32'h0, (mode ? IV_SHA224[(7-idx)*32 +: 32] : IV_SHA256[(7-idx)*32 +: 32])};
    end
    return w;
  endfunction

  function automatic logic [3:0] word_count(input int word_w, input logic mode);
    if (!mode) return CNT_FULL;
    return (word_w == 64) ? CNT_TRUNC64 : CNT_TRUNC32;
  endfunction

endpackage

// File: rtl/hash_word_add.sv
// One chaining word update: WORD_W-bit add, carry out discarded.
module hash_word_add #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/hash_state_reg.sv
// SHA-2 chaining-state register: IV load, per-word accumulate after each
// compression, and a ready/valid digest readout.
//
// state      | meaning
// -----------+---------------------------------------------
// ST_EMPTY   | no IV loaded since reset, accumulates ignored
// ST_HOLD    | H0..H7 valid, accepts accumulate / rd_start
// ST_READOUT | streaming H[idx] out, H frozen
module hash_state_reg #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        init_req,
  input  logic                        mode,
  input  logic                        acc_valid,
  input  logic [NUM_WORDS*WORD_W-1:0] acc_data,
  input  logic                        rd_start,
  output logic [NUM_WORDS*WORD_W-1:0] state_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_W-1:0]           out_word,
  output logic                        out_last,
  output logic                        busy
);
  import hash_pkg::*;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
    $error("hash_state_reg: WORD_W must be 32 or 64");
  end
  if (NUM_WORDS != 8) begin : g_bad_num_words
    $error("hash_state_reg: NUM_WORDS must be 8");
  end

  logic [WORD_W-1:0] h_q   [NUM_WORDS];
  logic [WORD_W-1:0] h_d   [NUM_WORDS];
  logic [WORD_W-1:0] h_sum [NUM_WORDS];
  hash_state_e       state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic [2:0]        last_idx;

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    hash_word_add #(.WORD_W(WORD_W)) u_add (
      .a   (h_q[i]),
      .b   (acc_data[(NUM_WORDS-1-i)*WORD_W +: WORD_W]),
      .sum (h_sum[i])
    );
    assign state_out[(NUM_WORDS-1-i)*WORD_W +: WORD_W] = h_q[i];
  end

  // Readout length follows the mode latched at init, not the live input.
  assign last_idx = 3'(word_count(WORD_W, mode_q) - 4'd1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    for (int i = 0; i < NUM_WORDS; i++) h_d[i] = h_q[i];

    if (init_req) begin
      for (int i = 0; i < NUM_WORDS; i++) h_d[i] = WORD_W'(iv_word(WORD_W, mode, i));
      mode_d      = mode;
      state_d     = ST_HOLD;
      idx_d       = 3'd0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (acc_valid) begin
            for (int i = 0; i < NUM_WORDS; i++) h_d[i] = h_sum[i];
          end
          if (rd_start) begin
            state_d     = ST_READOUT;
            idx_d       = 3'd0;
            out_valid_d = 1'b1;
          end
        end
        ST_READOUT: begin
          if (out_ready) begin
            if (idx_q == last_idx) begin
              state_d     = ST_HOLD;
              idx_d       = 3'd0;
              out_valid_d = 1'b0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= '0;
      state_q     <= ST_EMPTY;
      idx_q       <= 3'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) h_q[i] <= h_d[i];
      state_q     <= state_d;
      idx_q       <= idx_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
    end
  end

  // H is frozen during readout, so the word and last flag hold across stalls.
  assign out_valid = out_valid_q;
  assign out_word  = out_valid_q ? h_q[idx_q] : '0;
  assign out_last  = out_valid_q && (idx_q == last_idx);
  assign busy      = (state_q == ST_READOUT);

endmodule

// File: doc/hash_state_reg.md
HASH_STATE_REG -- requirements
Module: hash_state_reg

Interface
- REQ-001 Parameter WORD_W, default 32: hash word width. Legal values are 32 (SHA-256/224 family) and 64 (SHA-512/384 family); any other value is an elaboration error.
- REQ-002 Parameter NUM_WORDS, default 8: number of chaining words H0..H(NUM_WORDS-1). Fixed at 8; any other value is an elaboration error.
- REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
- REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
- REQ-005 Port init_req, input, 1: single-cycle pulse that loads the IV selected by mode.
- REQ-006 Port mode, input, 1: 0 selects full digest (SHA-256/SHA-512 IV); 1 selects truncated digest (SHA-224/SHA-384 IV). Sampled only when init_req is high.
- REQ-007 Port acc_valid, input, 1: a compression result is present on acc_data.
- REQ-008 Port acc_data, input, NUM_WORDS*WORD_W: working variables a..h; a occupies the MSBs.
- REQ-009 Port rd_start, input, 1: single-cycle pulse that starts digest readout.
- REQ-010 Port state_out, output, NUM_WORDS*WORD_W: current H0..H7 (H0 in the MSBs), fed to the compression core.
- REQ-011 Port out_valid, output, 1: out_word holds a valid digest word.
- REQ-012 Port out_ready, input, 1: downstream accepts out_word.
- REQ-013 Port out_word, output, WORD_W: current digest word.
- REQ-014 Port out_last, output, 1: asserted with the final digest word.
- REQ-015 Port busy, output, 1: high while the FSM is in READOUT.

Function
- REQ-016 The FSM has three states: EMPTY (no valid IV), HOLD (state valid), READOUT.
- REQ-017 init_req in any state loads the IV for the sampled mode into H0..H7, latches mode internally, moves to HOLD on the next edge, and aborts any readout in progress.
- REQ-018 In HOLD, acc_valid with no init_req updates each Hi to (Hi + word i) mod 2^WORD_W on the next edge; carries do not propagate between words.
- REQ-019 init_req takes precedence over acc_valid in the same cycle; the accumulate is discarded.
- REQ-020 acc_valid is ignored in EMPTY and in READOUT.
- REQ-021 rd_start in HOLD moves the FSM to READOUT with the word index at 0; rd_start in EMPTY or READOUT is ignored.
- REQ-022 In READOUT, out_valid is 1 and out_word equals H[index]; a transfer occurs when out_valid and out_ready are both high.
- REQ-023 out_word and out_last stay stable while out_valid is high and out_ready is low.
- REQ-024 The word count in READOUT is: mode 0 -> 8 words; mode 1, WORD_W=32 -> 7 words; mode 1, WORD_W=64 -> 6 words.
- REQ-025 out_last is high when index equals (count-1); the transfer of that word returns the FSM to HOLD, with H unchanged.
- REQ-026 state_out is a direct register output with zero latency; a new value is visible the cycle after an init or accumulate edge.
- REQ-027 out_valid is registered; the first word appears the cycle after rd_start.

Reset
- REQ-028 While rst_n is low: H0..H7 = 0, FSM = EMPTY, index = 0, latched mode = 0, out_valid = 0, out_last = 0, busy = 0, out_word = 0.
- REQ-029 Asserting reset mid-readout terminates it immediately; no further words are emitted after reset is released.

Structure
- REQ-030 The IV tables (SHA-256, SHA-224, SHA-512, SHA-384), the FSM state encoding, and the word-count constants are defined in a shared package, hash_pkg.
- REQ-031 A single sub-module, hash_word_add (a WORD_W-bit modular adder), is instantiated NUM_WORDS times; no other hierarchy is used.

Verification
- REQ-032 WORD_W=32, mode=0, init_req -> state_out H0=6a09e667, H7=5be0cd19; FSM in HOLD.
- REQ-033 WORD_W=32, after init mode 0, acc_valid with all words = ffffffff -> H0=6a09e666, H1=bb67ae84 (wrap, no inter-word carry).
- REQ-034 WORD_W=32, mode=1 init, rd_start, out_ready=1 -> 7 words c1059ed8 ... 64f98fa7, out_last on the 7th, then busy=0.
- REQ-035 WORD_W=64, mode=1 init, readout with out_ready toggled 1,0,1,... -> 6 words starting cbbb9d5dc1059ed8, each held stable during stalls, out_last on the 6th.
- REQ-036 init_req and acc_valid in the same cycle -> IV loaded, accumulate discarded; init_req during READOUT -> out_valid=0 next cycle, IV loaded.
- REQ-037 rst_n low mid-readout -> all outputs 0 asynchronously; acc_valid after release with no init_req -> H stays 0.
